// File: rtl/alu_operand_stage_if.sv
// Handshake, operand and writeback bundle between decode, the operand stage and execute.
// Optional forwarding port group is present when ALU_OPSTAGE_FWD_EN is defined.
interface alu_operand_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] imm;
  logic            use_imm;
  logic [3:0]      funct_in;
  logic [AW-1:0]   rd_in;
  logic            flush;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      funct;
  logic [AW-1:0]   rd_out;
`ifdef ALU_OPSTAGE_FWD_EN
  logic            fwd_valid;
  logic [AW-1:0]   fwd_rd;
  logic [XLEN-1:0] fwd_data;
`endif

  modport slave (
    input  in_valid, rs1, rs2, imm, use_imm, funct_in, rd_in, flush,
    input  wb_en, wb_addr, wb_data, out_ready,
`ifdef ALU_OPSTAGE_FWD_EN
    input  fwd_valid, fwd_rd, fwd_data,
`endif
    output in_ready, out_valid, a, b, funct, rd_out
  );

  modport master (
    output in_valid, rs1, rs2, imm, use_imm, funct_in, rd_in, flush,
    output wb_en, wb_addr, wb_data, out_ready,
`ifdef ALU_OPSTAGE_FWD_EN
    output fwd_valid, fwd_rd, fwd_data,
`endif
    input  in_ready, out_valid, a, b, funct, rd_out
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: register file read with writeback bypass, one-deep output buffer.
// Define ALU_OPSTAGE_FWD_EN to add an execute-result forwarding path ahead of the bypass.
module alu_operand_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input logic clk,
  input logic rst,
  alu_operand_stage_if.slave bus
);
  localparam int unsigned NREG = 2 ** AW;

  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            in_ready_c;
  logic            accept_c;

  logic            out_valid_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [3:0]      funct_q;
  logic [AW-1:0]   rd_q;

  // Read ports: x0 is zero, then forwarding (optional), then writeback bypass, then file.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (bus.rs1 != '0) begin
      rs1_val = regs[bus.rs1];
      if (bus.wb_en && bus.wb_addr == bus.rs1) rs1_val = bus.wb_data;
`ifdef ALU_OPSTAGE_FWD_EN
      if (bus.fwd_valid && bus.fwd_rd == bus.rs1) rs1_val = bus.fwd_data;
`endif
    end
    if (bus.rs2 != '0) begin
      rs2_val = regs[bus.rs2];
      if (bus.wb_en && bus.wb_addr == bus.rs2) rs2_val = bus.wb_data;
`ifdef ALU_OPSTAGE_FWD_EN
      if (bus.fwd_valid && bus.fwd_rd == bus.rs2) rs2_val = bus.fwd_data;
`endif
    end
  end

  always_comb begin
    in_ready_c = (!out_valid_q || bus.out_ready) && !bus.flush;
    accept_c   = bus.in_valid && in_ready_c;
  end

  // Output buffer; flush suppresses accept through in_ready and then drops the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      funct_q     <= '0;
      rd_q        <= '0;
    end else if (accept_c) begin
      out_valid_q <= 1'b1;
      a_q         <= rs1_val;
      b_q         <= bus.use_imm ? bus.imm : rs2_val;
      funct_q     <= bus.funct_in;
      rd_q        <= bus.rd_in;
    end else if (bus.flush || bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Register file; writeback ignores the handshake and flush, entry 0 never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != '0) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.funct     = funct_q;
  assign bus.rd_out    = rd_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed literal cases plus randomized traffic
// compared every cycle against a behavioural model of the stage.
module tb_alu_operand_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_operand_stage_if #(.XLEN(32), .AW(5)) bus ();
  alu_operand_stage #(.XLEN(32), .AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state
  logic [31:0] mregs [32];
  logic        m_valid;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_funct;
  logic [4:0]  m_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] mrd(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
`ifdef ALU_OPSTAGE_FWD_EN
    if (bus.fwd_valid && bus.fwd_rd == r) return bus.fwd_data;
`endif
    if (bus.wb_en && bus.wb_addr == r) return bus.wb_data;
    return mregs[r];
  endfunction

  function automatic logic m_in_ready();
    return (!m_valid || bus.out_ready) && !bus.flush;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
      m_valid = 1'b0; m_a = 32'h0; m_b = 32'h0; m_funct = 4'h0; m_rd = 5'h0;
    end else begin
      if (bus.in_valid && m_in_ready()) begin
        m_valid = 1'b1;
        m_a     = mrd(bus.rs1);
        m_b     = bus.use_imm ? bus.imm : mrd(bus.rs2);
        m_funct = bus.funct_in;
        m_rd    = bus.rd_in;
      end else if (bus.flush || bus.out_ready) begin
        m_valid = 1'b0;
      end
      if (bus.wb_en && bus.wb_addr != 5'd0) mregs[bus.wb_addr] = bus.wb_data;
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("in_ready", 32'(bus.in_ready), 32'(m_in_ready()));
    if (m_valid || rst) begin
      chk("a", bus.a, m_a);
      chk("b", bus.b, m_b);
      chk("funct", 32'(bus.funct), 32'(m_funct));
      chk("rd_out", 32'(bus.rd_out), 32'(m_rd));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0; bus.use_imm = 1'b0;
    bus.funct_in = '0; bus.rd_in = '0; bus.flush = 1'b0; bus.wb_en = 1'b0;
    bus.wb_addr = '0; bus.wb_data = '0; bus.out_ready = 1'b1;
`ifdef ALU_OPSTAGE_FWD_EN
    bus.fwd_valid = 1'b0; bus.fwd_rd = '0; bus.fwd_data = '0;
`endif
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic ui,
                       input logic [31:0] im, input logic [3:0] fn, input logic [4:0] rd);
    bus.in_valid = 1'b1; bus.rs1 = r1; bus.rs2 = r2; bus.use_imm = ui;
    bus.imm = im; bus.funct_in = fn; bus.rd_in = rd;
  endtask

  task automatic wb(input logic en, input logic [4:0] ad, input logic [31:0] d);
    bus.wb_en = en; bus.wb_addr = ad; bus.wb_data = d;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Write then read back
    wb(1, 5'd1, 32'h000A4321); step();
    wb(1, 5'd2, 32'h000A4322); step();
    wb(0, 5'd0, 32'h0); issue(5'd1, 5'd2, 1'b0, 32'h0, 4'b0000, 5'd3); step();
    chk("rb_a", bus.a, 32'h000A4321);
    chk("rb_b", bus.b, 32'h000A4322);
    chk("rb_funct", 32'(bus.funct), 32'h0);
    chk("rb_rd", 32'(bus.rd_out), 32'd3);
    chk("rb_valid", 32'(bus.out_valid), 32'h1);

    // Same-cycle bypass, x0, immediate
    wb(1, 5'd4, 32'hDEADBEEF); issue(5'd4, 5'd4, 1'b0, 32'h0, 4'h5, 5'd6); step();
    chk("byp_a", bus.a, 32'hDEADBEEF);
    chk("byp_b", bus.b, 32'hDEADBEEF);
    wb(1, 5'd0, 32'h1); issue(5'd0, 5'd0, 1'b0, 32'h0, 4'h1, 5'd0); step();
    wb(0, 5'd0, 32'h0); issue(5'd0, 5'd1, 1'b1, 32'hFFFFFFF0, 4'h2, 5'd7); step();
    chk("x0_a", bus.a, 32'h0);
    chk("imm_b", bus.b, 32'hFFFFFFF0);

    // Backpressure: buffer holds while x1 is rewritten
    issue(5'd1, 5'd2, 1'b0, 32'h0, 4'h3, 5'd8); step();
    chk("bp_load_a", bus.a, 32'h000A4321);
    bus.out_ready = 1'b0; issue(5'd2, 5'd1, 1'b0, 32'h0, 4'h4, 5'd9); wb(1, 5'd1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      step();
      chk("bp_hold_a", bus.a, 32'h000A4321);
      chk("bp_hold_rd", 32'(bus.rd_out), 32'd8);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'h1);
    end
    wb(0, 5'd0, 32'h0); bus.out_ready = 1'b1; step();
    chk("bp_resume_a", bus.a, 32'h000A4322);
    chk("bp_resume_b", bus.b, 32'h0);
    issue(5'd1, 5'd4, 1'b0, 32'h0, 4'h6, 5'd10); step();
    chk("bp_next_a", bus.a, 32'h0);
    chk("bp_next_rd", 32'(bus.rd_out), 32'd10);

    // Flush drops buffered and incoming entries
    issue(5'd2, 5'd2, 1'b0, 32'h0, 4'h7, 5'd11); bus.flush = 1'b1;
    #1 chk("fl_in_ready", 32'(bus.in_ready), 32'h0);
    step();
    chk("fl_valid", 32'(bus.out_valid), 32'h0);
    bus.flush = 1'b0; issue(5'd4, 5'd2, 1'b0, 32'h0, 4'h8, 5'd12); step();
    chk("fl_after_valid", 32'(bus.out_valid), 32'h1);
    chk("fl_after_a", bus.a, 32'hDEADBEEF);

`ifdef ALU_OPSTAGE_FWD_EN
    bus.fwd_valid = 1'b1; bus.fwd_rd = 5'd1; bus.fwd_data = 32'h12345678;
    wb(1, 5'd1, 32'h1); issue(5'd1, 5'd0, 1'b0, 32'h0, 4'h9, 5'd13); step();
    chk("fwd_a", bus.a, 32'h12345678);
    bus.fwd_valid = 1'b0; wb(0, 5'd0, 32'h0); issue(5'd1, 5'd0, 1'b0, 32'h0, 4'h9, 5'd13); step();
    chk("fwd_reg_a", bus.a, 32'h1);
`endif

    // Randomized traffic; narrow address range forces bypass/forward collisions
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      bus.rs1       = 5'($urandom_range(0, 7));
      bus.rs2       = 5'($urandom_range(0, 7));
      bus.use_imm   = $urandom_range(0, 1) == 1;
      bus.imm       = $urandom;
      bus.funct_in  = 4'($urandom);
      bus.rd_in     = 5'($urandom);
      wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
`ifdef ALU_OPSTAGE_FWD_EN
      bus.fwd_valid = $urandom_range(0, 2) == 0;
      bus.fwd_rd    = 5'($urandom_range(0, 7));
      bus.fwd_data  = $urandom;
`endif
      step();
    end

    // Asynchronous reset mid-stream with a valid entry buffered
    idle(); wb(1, 5'd5, 32'hCAFEF00D); issue(5'd3, 5'd4, 1'b0, 32'h0, 4'hF, 5'd31); step();
    chk("rst_pre_valid", 32'(bus.out_valid), 32'h1);
    idle(); rst = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_a", bus.a, 32'h0);
    chk("rst_b", bus.b, 32'h0);
    chk("rst_funct", 32'(bus.funct), 32'h0);
    chk("rst_rd", 32'(bus.rd_out), 32'h0);
    step();
    rst = 1'b0;
    issue(5'd5, 5'd5, 1'b0, 32'h0, 4'h1, 5'd1); step();
    chk("post_rst_valid", 32'(bus.out_valid), 32'h1);
    chk("post_rst_a", bus.a, 32'h0);
    idle(); step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch stage directly upstream of the 32-bit ALU (ports a, b, funct).
- Holds the 32-entry architectural register file and selects operand b from register or immediate.
- Registers {a, b, funct, rd} into a one-deep output buffer with a valid/ready handshake toward the ALU/execute stage.
- Accepts register writeback from later stages, with same-cycle write-through bypass.

Parameters:
- XLEN, 32, datapath width of operands and register entries
- AW, 5, register address width; register count is 2**AW; entry 0 reads as zero

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  decoded instruction presented
- in_ready  output  1  stage can accept the instruction this cycle
- rs1  input  AW  source register for operand a
- rs2  input  AW  source register for operand b when use_imm=0
- imm  input  XLEN  immediate, already sign-extended
- use_imm  input  1  1: b=imm; 0: b=reg[rs2]
- funct_in  input  4  ALU function code, passed through unchanged
- rd_in  input  AW  destination register, passed through
- flush  input  1  discard buffered and incoming instruction
- wb_en  input  1  register write enable
- wb_addr  input  AW  write address
- wb_data  input  XLEN  write data
- out_valid  output  1  a/b/funct/rd_out are valid
- out_ready  input  1  downstream consumes the buffered entry
- a  output  XLEN  ALU operand a
- b  output  XLEN  ALU operand b
- funct  output  4  ALU function code
- rd_out  output  AW  destination register

Behaviour:
- Reset (async, rst=1): out_valid=0, a=0, b=0, funct=0, rd_out=0, all register entries=0. State is cleared immediately, mid-transaction included. First acceptance is possible on the first rising edge after rst deasserts.
- in_ready = (!out_valid || out_ready) && !flush. It is purely combinational, and in_ready=0 is permitted while in_valid=0.
- Accept = in_valid && in_ready. On accept, at the next edge:
  - out_valid<=1
  - a<=rd(rs1)
  - b<=use_imm ? imm : rd(rs2)
  - funct<=funct_in
  - rd_out<=rd_in
- Latency: exactly 1 cycle from accept to out_valid.
- Full throughput: one instruction per cycle while out_ready=1.
- Drain: out_valid && out_ready && !accept -> out_valid<=0. Data regs hold their value; downstream must not use them while out_valid=0.
- Stall: out_valid && !out_ready -> all outputs hold. Operands are sampled at accept; later writebacks do not alter a buffered entry.
- Flush: flush=1 -> out_valid<=0 at the next edge and nothing is accepted that cycle. Flush has priority over out_ready and in_valid.
- Read function rd(r):
  - r==0 -> 0
  - else if wb_en && wb_addr==r -> wb_data (write-through bypass)
  - else reg[r]
- Write: wb_en && wb_addr!=0 -> reg[wb_addr]<=wb_data at the edge. Writes to entry 0 are ignored. Writeback is independent of the handshake and of flush.
- Simultaneous accept and write to the same register: the buffered operand gets the new value, and the register file gets the new value.
- rs1==rs2: both operands read the same value, including the bypassed value.
- Widths: no arithmetic in this stage. All values pass bit-exact; imm is not extended further.

Optional Feature:
- Macro: ALU_OPSTAGE_FWD_EN.
- Defined: adds inputs fwd_valid (1), fwd_rd (AW) and fwd_data (XLEN), driven from the ALU result of the instruction currently in execute.
- Read priority in rd(r):
  - r==0 -> 0
  - fwd_valid && fwd_rd==r -> fwd_data
  - wb bypass
  - reg[r]
- fwd_* never writes the register file.
- Undefined: fwd_* ports do not exist and rd(r) is as above. Behaviour is otherwise identical.

Test Plan:
- Reset value: hold rst=1 mid-stream with out_valid=1 -> out_valid, a, b, funct and rd_out all 0 within the same cycle. After release, rs1=5 reads 0.
- Write and read back:
  - Stimulus: wb x1=32'h000A4321 and x2=32'h000A4322, then accept rs1=1, rs2=2, use_imm=0, funct_in=4'b0000, rd_in=3.
  - Response: one cycle later a=32'h000A4321, b=32'h000A4322, funct=0, rd_out=3, out_valid=1.
- Bypass and x0:
  - Same-cycle wb x4=32'hDEADBEEF with accept rs1=4 -> a=32'hDEADBEEF.
  - wb x0=32'h1 then rs1=0 -> a=0.
  - use_imm=1, imm=32'hFFFFFFF0 -> b=32'hFFFFFFF0.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with in_valid=1; meanwhile wb rewrites x1=32'h0.
  - Response: in_ready=0, and outputs hold the original values for all 3 cycles.
  - Then out_ready=1: next instruction appears 1 cycle later with no gap, then one instruction per cycle.
- Flush: flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, and the incoming instruction does not appear. The instruction presented after flush drops is accepted normally.
- Forwarding (ALU_OPSTAGE_FWD_EN defined):
  - Stimulus: fwd_valid=1, fwd_rd=1, fwd_data=32'h12345678, wb x1=32'h1, accept rs1=1.
  - Response: a=32'h12345678, and reg x1 later reads 32'h1.
